// File: rtl/softmax_deadlock_detector.sv
// Softmax dataflow deadlock detector.
// Watches per-process idle/block vectors and AXIS block vector; declares a
// sticky deadlock when a stall persists unchanged for STALL_THRESH cycles,
// and captures a snapshot plus cause classification at detection time.
module softmax_deadlock_detector #(
  parameter int NUM_INST     = 4,
  parameter int NUM_AXIS     = 2,
  parameter int STALL_THRESH = 1024,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                deadlock_cause,
  output logic [IDX_W-1:0]    first_blocked_idx,
  output logic [NUM_INST-1:0] block_snapshot,
  output logic [NUM_AXIS-1:0] axis_snapshot,
  output logic [7:0]          deadlock_count,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef enum logic [1:0] {RUN, SUSPECT, DEADLOCK} state_t;

  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(STALL_THRESH - 1);

  state_t              state;
  logic [NUM_INST-1:0] idle_q, idle_qq, block_q, block_qq;
  logic [NUM_AXIS-1:0] axis_q, axis_qq;
  logic                all_idle, stall, changed;
  logic [NUM_INST-1:0] active_blk;
  logic [IDX_W-1:0]    first_idx;

  // Register inputs once, and keep the previous sample for change detection
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idle_q   <= '0;
      idle_qq  <= '0;
      block_q  <= '0;
      block_qq <= '0;
      axis_q   <= '0;
      axis_qq  <= '0;
    end else begin
      idle_q   <= inst_idle_sigs;
      idle_qq  <= idle_q;
      block_q  <= inst_block_sigs;
      block_qq <= block_q;
      axis_q   <= axis_block_sigs;
      axis_qq  <= axis_q;
    end
  end

  // Stall/progress terms and lowest-index active blocked process
  always_comb begin
    active_blk = block_q & ~idle_q;
    all_idle   = &idle_q;
    stall      = (&(idle_q | block_q)) & (|active_blk);
    changed    = (block_q != block_qq) | (idle_q != idle_qq) | (axis_q != axis_qq);
    first_idx  = '0;
    for (int i = NUM_INST - 1; i >= 0; i--)
      if (active_blk[i]) first_idx = IDX_W'(i);
  end

  // Detector FSM; clear has priority so it also beats a same-edge detection
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state             <= RUN;
      block             <= 1'b0;
      deadlock_cause    <= 1'b0;
      first_blocked_idx <= '0;
      block_snapshot    <= '0;
      axis_snapshot     <= '0;
      deadlock_count    <= '0;
      stall_cycles      <= '0;
    end else if (clear) begin
      state        <= RUN;
      block        <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (state)
        RUN: begin
          stall_cycles <= '0;
          if (stall) state <= SUSPECT;
        end
        SUSPECT: begin
          if (!stall || all_idle) begin
            state        <= RUN;
            stall_cycles <= '0;
          end else if (changed) begin
            stall_cycles <= '0;
          end else if (stall_cycles == THR_M1) begin
            // Counter holds at THRESH-1 while in DEADLOCK
            state             <= DEADLOCK;
            block             <= 1'b1;
            block_snapshot    <= block_q;
            axis_snapshot     <= axis_q;
            deadlock_cause    <= |axis_q;
            first_blocked_idx <= first_idx;
            if (deadlock_count != 8'hFF) deadlock_count <= deadlock_count + 8'd1;
          end else begin
            stall_cycles <= stall_cycles + CNT_W'(1);
          end
        end
        DEADLOCK: block <= 1'b1;
        default: begin
          state        <= RUN;
          block        <= 1'b0;
          stall_cycles <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_deadlock_detector.sv
// Bench for softmax_deadlock_detector: directed scenarios plus random
// stimulus, all checked against a behavioural model of the detection rules.
module tb_softmax_deadlock_detector;
  localparam int NI = 4, NA = 2, TH = 16, CW = 16, IW = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [NI-1:0] idle = '1, blk = '0;
  logic [NA-1:0] axis = '0;
  logic          clr = 1'b0;
  logic          block, deadlock_cause;
  logic [IW-1:0] first_blocked_idx;
  logic [NI-1:0] block_snapshot;
  logic [NA-1:0] axis_snapshot;
  logic [7:0]    deadlock_count;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0, n_errors = 0;

  softmax_deadlock_detector #(.NUM_INST(NI), .NUM_AXIS(NA), .STALL_THRESH(TH), .CNT_W(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .inst_idle_sigs(idle), .inst_block_sigs(blk), .axis_block_sigs(axis),
    .clear(clr), .block(block), .deadlock_cause(deadlock_cause),
    .first_blocked_idx(first_blocked_idx), .block_snapshot(block_snapshot),
    .axis_snapshot(axis_snapshot), .deadlock_count(deadlock_count),
    .stall_cycles(stall_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference model: mode 0=running, 1=suspicious, 2=deadlocked
  logic [NI-1:0] m_iq, m_iqq, m_bq, m_bqq, m_bsnap;
  logic [NA-1:0] m_aq, m_aqq, m_asnap;
  int m_mode, m_cnt, m_count, m_idx;
  logic m_cause;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit f_stall(input logic [NI-1:0] i, input logic [NI-1:0] b);
    bit every = 1, any = 0;
    for (int k = 0; k < NI; k++) begin
      if (!(i[k] || b[k])) every = 0;
      if (b[k] && !i[k]) any = 1;
    end
    return every && any;
  endfunction

  function automatic int f_first(input logic [NI-1:0] i, input logic [NI-1:0] b);
    for (int k = 0; k < NI; k++) if (b[k] && !i[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_iq = '0; m_iqq = '0; m_bq = '0; m_bqq = '0; m_aq = '0; m_aqq = '0;
    m_bsnap = '0; m_asnap = '0; m_mode = 0; m_cnt = 0; m_count = 0;
    m_idx = 0; m_cause = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    bit st, ai, ch;
    if (!ap_rst_n) begin
      model_reset();
      return;
    end
    st = f_stall(m_iq, m_bq);
    ai = (m_iq == '1);
    ch = (m_iq != m_iqq) || (m_bq != m_bqq) || (m_aq != m_aqq);
    if (clr) begin
      m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_cnt = 0;
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!st || ai) begin
        m_mode = 0; m_cnt = 0;
      end else if (ch) m_cnt = 0;
      else if (m_cnt == TH - 1) begin
        m_mode = 2;
        m_bsnap = m_bq; m_asnap = m_aq; m_cause = (m_aq != 0);
        m_idx = f_first(m_iq, m_bq);
        if (m_count < 255) m_count++;
      end else m_cnt++;
    end
    m_iqq = m_iq; m_bqq = m_bq; m_aqq = m_aq;
    m_iq = idle; m_bq = blk; m_aq = axis;
  endtask

  task automatic check_all();
    chk("block", block, (m_mode == 2));
    chk("cause", deadlock_cause, m_cause);
    chk("first_idx", first_blocked_idx, m_idx);
    chk("blk_snap", block_snapshot, m_bsnap);
    chk("axis_snap", axis_snapshot, m_asnap);
    chk("dl_count", deadlock_count, m_count);
    if (m_mode != 2) chk("stall_cycles", stall_cycles, m_cnt);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    model_step();
    @(negedge ap_clk);
    check_all();
  endtask

  // Ticks until block rises; the bound makes a missing detection a failed check
  task automatic wait_block(inout int n);
    while (block !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) tick();
    ap_rst_n = 1'b1;
  endtask

  initial begin
    int n, mx, len;
    model_reset();
    repeat (2) @(negedge ap_clk);
    check_all();
    chk("rst_block", block, 0);
    chk("rst_count", deadlock_count, 0);
    ap_rst_n = 1'b1;
    repeat (3) tick();

    // Process 1 active and blocked, others idle: block after E+THRESH+1 (tick 18)
    idle = 4'b1101; blk = 4'b0010; axis = 2'b00;
    n = 0; wait_block(n);
    chk("t1_latency", n, TH + 2);
    chk("t1_idx", first_blocked_idx, 1);
    chk("t1_snap", block_snapshot, 4'b0010);
    chk("t1_cause", deadlock_cause, 0);
    chk("t1_count", deadlock_count, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t1_clear", block, 0);

    // Block pattern toggles every 8 cycles: counter never passes 7
    mx = 0;
    for (int c = 0; c < 64; c++) begin
      if (c % 8 == 0) blk = (blk == 4'b0010) ? 4'b0110 : 4'b0010;
      tick();
      if (int'(stall_cycles) > mx) mx = int'(stall_cycles);
      chk("tog_block", block, 0);
    end
    chk("tog_max", mx, 7);

    // Everything idle
    idle = '1; blk = '0;
    repeat (100) tick();
    chk("idle_block", block, 0);
    chk("idle_cnt", stall_cycles, 0);

    // AXIS starvation cause, clear, re-detection
    do_reset();
    idle = 4'b1101; blk = 4'b0010; axis = 2'b10;
    n = 0; wait_block(n);
    chk("ax_latency", n, TH + 2);
    chk("ax_cause", deadlock_cause, 1);
    chk("ax_snap", axis_snapshot, 2'b10);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ax_clear", block, 0);
    chk("ax_hold_snap", axis_snapshot, 2'b10);
    n = 1; wait_block(n);
    chk("ax_redetect", n, TH + 2);
    chk("ax_count", deadlock_count, 2);

    // Clear on the threshold edge wins
    do_reset();
    axis = 2'b00;
    n = 0;
    while (stall_cycles != CW'(TH - 1) && n < 60) begin tick(); n++; end
    chk("thr_reach", stall_cycles, TH - 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("thr_block", block, 0);
    chk("thr_count", deadlock_count, 0);
    chk("thr_cnt", stall_cycles, 0);

    // Reset while deadlocked
    n = 0; wait_block(n);
    chk("rd_block", block, 1);
    do_reset();
    n = 0; wait_block(n);
    chk("rd_latency", n, TH + 2);
    chk("rd_count", deadlock_count, 1);

    // Random segments: mostly stall-like patterns held for random lengths
    for (int s = 0; s < 80; s++) begin
      blk = NI'($urandom);
      if ($urandom_range(0, 3) == 0) idle = NI'($urandom);
      else idle = ~blk | NI'($urandom & $urandom & $urandom);
      axis = NA'($urandom);
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        clr = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 30) == 0) axis = NA'($urandom);
        tick();
      end
      clr = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
